// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a fall-through FIFO read port and packs
// them little-endian into 32-bit words on a valid/ready output with byte
// enables. Partial words leave on an explicit flush or after an idle timeout.
module fifo_word_packer #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  rd_data,
    output logic        rd_en,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_be
);
    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDLE_W = 8;

    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);
    // Last idle count before the automatic flush is armed.
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(LANES);

    logic [WORD_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]  acc_cnt, acc_cnt_nxt;
    logic              flush_pending, flush_pending_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic              out_valid_nxt;
    logic [WORD_W-1:0] out_data_nxt;
    logic [LANES-1:0]  out_be_nxt;

    logic              flush_req;
    logic              full;
    logic              partial;
    logic              out_free;
    logic              xfer;
    logic              pop;
    logic [LANES-1:0]  be_mask;
    logic [WORD_W-1:0] lane_mask;

    // Transfer / pop qualification.
    assign flush_req = flush | flush_pending;
    assign full      = (acc_cnt == CNT_FULL);
    assign partial   = (acc_cnt != '0) && (acc_cnt < CNT_FULL);
    assign out_free  = ~out_valid | out_ready;
    assign xfer      = (full | (flush_req & (acc_cnt != '0))) & out_free;
    assign pop       = ~rst & ~fifo_empty & ~flush_req & (~full | xfer);
    assign rd_en     = pop;

    // Byte enables and data mask for the lanes currently filled.
    always_comb begin
        be_mask   = '0;
        lane_mask = '0;
        case (acc_cnt)
            3'd0:    be_mask = 4'b0000;
            3'd1:    be_mask = 4'b0001;
            3'd2:    be_mask = 4'b0011;
            3'd3:    be_mask = 4'b0111;
            default: be_mask = 4'b1111;
        endcase
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be_mask[i]}};
        end
    end

    // Next-state: accumulator, output register, flush and idle tracking.
    always_comb begin
        acc_nxt           = acc;
        acc_cnt_nxt       = acc_cnt;
        flush_pending_nxt = flush_pending;
        idle_cnt_nxt      = '0;
        out_valid_nxt     = out_valid;
        out_data_nxt      = out_data;
        out_be_nxt        = out_be;

        if (xfer) begin
            out_data_nxt      = acc & lane_mask;
            out_be_nxt        = be_mask;
            out_valid_nxt     = 1'b1;
            acc_cnt_nxt       = '0;
            flush_pending_nxt = 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (pop) begin
            if (xfer) begin
                acc_nxt[BYTE_W-1:0] = rd_data;
                acc_cnt_nxt         = CNT_W'(1);
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (acc_cnt == CNT_W'(i)) begin
                        acc_nxt[i*BYTE_W +: BYTE_W] = rd_data;
                    end
                end
                acc_cnt_nxt = acc_cnt + CNT_W'(1);
            end
        end

        // A flush against an empty accumulator is dropped.
        if (!xfer && flush && (acc_cnt != '0)) begin
            flush_pending_nxt = 1'b1;
        end

        // Idle timer only runs while a partial word sits untouched.
        if (partial && !pop && !flush_req) begin
            if (TIMEOUT_EN && (idle_cnt == IDLE_LAST)) begin
                flush_pending_nxt = 1'b1;
                idle_cnt_nxt      = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + IDLE_W'(1);
            end
        end
    end

    // State registers with synchronous reset; mid-word bytes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            acc_cnt       <= '0;
            flush_pending <= 1'b0;
            idle_cnt      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_be        <= '0;
        end else begin
            acc           <= acc_nxt;
            acc_cnt       <= acc_cnt_nxt;
            flush_pending <= flush_pending_nxt;
            idle_cnt      <= idle_cnt_nxt;
            out_valid     <= out_valid_nxt;
            out_data      <= out_data_nxt;
            out_be        <= out_be_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: directed sequences, a flush vector table and a
// randomized run checked against a byte-stream reference.
module tb_fifo_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        out_ready;
    logic        fifo_empty, rd_en, out_valid;
    logic [7:0]  rd_data;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        fifo_empty0, rd_en0, out_valid0;
    logic [7:0]  rd_data0;
    logic [31:0] out_data0;
    logic [3:0]  out_be0;

    fifo_word_packer #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_data(rd_data),
        .rd_en(rd_en), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_be(out_be)
    );

    fifo_word_packer #(.TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty0), .rd_data(rd_data0),
        .rd_en(rd_en0), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_be(out_be0)
    );

    // FIFO contents and observation log
    logic [7:0]  fq[$];
    logic [7:0]  fq0[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_be[$];
    logic [63:0] ren_hist;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_n, first_ov, last_pop, ov0_cycles;
    logic        s_ren, s_ov, s_ren0, s_ov0;
    logic [31:0] s_data;
    logic [3:0]  s_be;

    // Randomized-run reference: every pushed byte, and how many came out
    logic [7:0]  sent[$];
    int          rx_ptr;

    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] bytes_in;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [3:0]  exp_lat;
    } fvec_t;
    fvec_t fvec [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty  = (fq.size() == 0);
        fifo_empty0 = (fq0.size() == 0);
        rd_data  = 8'h00;
        rd_data0 = 8'h00;
        if (fq.size() != 0)  rd_data  = fq[0];
        if (fq0.size() != 0) rd_data0 = fq0[0];
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_sync();
    endtask

    task automatic clear_log();
        got_data.delete();
        got_be.delete();
        ren_hist   = '0;
        cyc_n      = 0;
        first_ov   = -1;
        last_pop   = -1;
        ov0_cycles = 0;
    endtask

    // One clock: drive inputs, sample at negedge, apply FIFO pops after the edge.
    task automatic cycle(input logic fl, input logic rdy);
        flush     = fl;
        out_ready = rdy;
        @(negedge clk);
        s_ren  = rd_en;
        s_ov   = out_valid;
        s_data = out_data;
        s_be   = out_be;
        s_ren0 = rd_en0;
        s_ov0  = out_valid0;
        check("rd_en_while_empty", 32'(s_ren & fifo_empty), 32'd0);
        check("rd_en0_while_empty", 32'(s_ren0 & fifo_empty0), 32'd0);
        if (cyc_n < 64) ren_hist[6'(cyc_n)] = s_ren;
        if (s_ren) last_pop = cyc_n;
        if (s_ov && first_ov < 0) first_ov = cyc_n;
        if (s_ov0) ov0_cycles++;
        if (s_ov && rdy) begin
            got_data.push_back(s_data);
            got_be.push_back(s_be);
        end
        @(posedge clk);
        #1;
        if (s_ren && fq.size() != 0) void'(fq.pop_front());
        if (s_ren0 && fq0.size() != 0) void'(fq0.pop_front());
        fifo_sync();
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        fq.delete();
        fq0.delete();
        fifo_sync();
        repeat (n) cycle(1'b0, 1'b1);
        rst = 1'b0;
        clear_log();
    endtask

    function automatic logic [31:0] gw(input int i);
        if (i < got_data.size()) return got_data[i];
        return 'x;
    endfunction

    function automatic logic [3:0] gb(input int i);
        if (i < got_be.size()) return got_be[i];
        return 'x;
    endfunction

    // Random-run cycle: each presented word must be the next bytes of the stream.
    task automatic rand_cycle(input logic fl, input logic rdy);
        int  nb;
        logic ok;
        cycle(fl, rdy);
        if (fl) check("flush_blocks_pop", 32'(s_ren), 32'd0);
        if (s_ov) begin
            ok = 1'b1;
            case (s_be)
                4'b0001: nb = 1;
                4'b0011: nb = 2;
                4'b0111: nb = 3;
                4'b1111: nb = 4;
                default: begin nb = 0; ok = 1'b0; end
            endcase
            for (int i = 0; i < 4; i++) begin
                if (i < nb) begin
                    if (rx_ptr + i >= sent.size()) ok = 1'b0;
                    else if (s_data[8*i +: 8] !== sent[rx_ptr + i]) ok = 1'b0;
                end else if (s_data[8*i +: 8] !== 8'h00) begin
                    ok = 1'b0;
                end
            end
            check("rand_word", 32'(ok), 32'd1);
            if (rdy) rx_ptr += nb;
        end
    endtask

    initial begin
        fvec[0] = '{3'd1, 32'hFFFFFF5A, 32'h0000005A, 4'b0001, 4'd2};
        fvec[1] = '{3'd2, 32'hFFFFBBAA, 32'h0000BBAA, 4'b0011, 4'd3};
        fvec[2] = '{3'd3, 32'hFF030201, 32'h00030201, 4'b0111, 4'd4};
        fvec[3] = '{3'd4, 32'hEFBEADDE, 32'hEFBEADDE, 4'b1111, 4'd5};

        // Reset held 3 cycles with 5 bytes waiting
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        clear_log();
        fifo_sync();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1);
            check("reset_rd_en", 32'(s_ren), 32'd0);
            check("reset_out_valid", 32'(s_ov), 32'd0);
            check("reset_out_data", s_data, 32'h0);
            check("reset_out_be", 32'(s_be), 32'd0);
        end
        check("reset_fifo_untouched", fq.size(), 32'd5);

        // Full-rate packing
        do_reset(2);
        for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1);
        check("full_rd_en_pattern", 32'(ren_hist[15:0]), 32'h00FF);
        check("full_first_valid_cycle", first_ov, 32'd5);
        check("full_word_count", got_data.size(), 32'd2);
        check("full_word0", gw(0), 32'h44332211);
        check("full_be0", 32'(gb(0)), 32'hF);
        check("full_word1", gw(1), 32'h88776655);
        check("full_be1", 32'(gb(1)), 32'hF);

        // Back-pressure: ready low for 10 cycles
        do_reset(2);
        for (int i = 0; i < 12; i++) push(8'(8'hC0 + i));
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, (k >= 10));
            if (k >= 5 && k < 10) begin
                check("bp_hold_valid", 32'(s_ov), 32'd1);
                check("bp_hold_data", s_data, 32'hC3C2C1C0);
                check("bp_hold_be", 32'(s_be), 32'hF);
            end
        end
        check("bp_rd_en_pattern", 32'(ren_hist[15:0]), 32'h3CFF);
        check("bp_word_count", got_data.size(), 32'd3);
        check("bp_word0", gw(0), 32'hC3C2C1C0);
        check("bp_word1", gw(1), 32'hC7C6C5C4);
        check("bp_word2", gw(2), 32'hCBCAC9C8);

        // Flush table: n bytes then a flush right after the last pop
        foreach (fvec[v]) begin
            do_reset(2);
            for (int i = 0; i < int'(fvec[v].n); i++) push(fvec[v].bytes_in[8*i +: 8]);
            for (int k = 0; k < 20; k++) cycle((k == int'(fvec[v].n)), 1'b1);
            check($sformatf("flush%0d_count", v), got_data.size(), 32'd1);
            check($sformatf("flush%0d_data", v), gw(0), fvec[v].exp_data);
            check($sformatf("flush%0d_be", v), 32'(gb(0)), 32'(fvec[v].exp_be));
            check($sformatf("flush%0d_latency", v), first_ov, 32'(fvec[v].exp_lat));
        end

        // Flush with an empty accumulator is a no-op, popping still works afterwards
        do_reset(2);
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 15; k++) cycle(1'b0, 1'b1);
        check("empty_flush_no_word", got_data.size(), 32'd0);
        for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1);
        check("empty_flush_then_word", gw(0), 32'h64636261);
        check("empty_flush_then_count", got_data.size(), 32'd1);

        // Timeout with TIMEOUT=8
        do_reset(2);
        push(8'h5A);
        for (int k = 0; k < 25; k++) cycle(1'b0, 1'b1);
        check("to_pop_cycle", last_pop, 32'd0);
        check("to_valid_cycle", first_ov, 32'(last_pop + 10));
        check("to_count", got_data.size(), 32'd1);
        check("to_data", gw(0), 32'h0000005A);
        check("to_be", 32'(gb(0)), 32'h1);

        // Timeout disabled
        do_reset(2);
        fq0.push_back(8'h5A);
        fifo_sync();
        for (int k = 0; k < 100; k++) cycle(1'b0, 1'b1);
        check("to0_popped", fq0.size(), 32'd0);
        check("to0_no_output", ov0_cycles, 32'd0);
        check("to0_be_clear", 32'(out_be0), 32'd0);

        // Reset mid-word discards the partial bytes
        do_reset(2);
        push(8'hA1); push(8'hA2); push(8'hA3);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        rst = 1'b1;
        cycle(1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'hB1 + i));
        for (int k = 0; k < 15; k++) cycle(1'b0, 1'b1);
        check("rstmid_count", got_data.size(), 32'd1);
        check("rstmid_data", gw(0), 32'hB4B3B2B1);
        check("rstmid_be", 32'(gb(0)), 32'hF);

        // Randomized traffic against the byte-stream reference
        do_reset(2);
        sent.delete();
        rx_ptr = 0;
        for (int k = 0; k < 2000; k++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) < 5 && fq.size() < 16) begin
                b = 8'($urandom);
                push(b);
                sent.push_back(b);
            end
            rand_cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 40; k++) rand_cycle(1'b0, 1'b1);
        rand_cycle(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) rand_cycle(1'b0, 1'b1);
        check("rand_all_bytes_out", rx_ptr, sent.size());
        check("rand_fifo_drained", fq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
